fetch_prefetch_stage: RTL and testbench

- Parametrised fetch stage: PC generation, a pipelined instruction-memory request/response interface, a DEPTH-entry in-order prefetch queue, and the F/D pipeline register.
- Sits between the instruction memory and the decode stage.
- Unlike the single-register fetch stage, it tolerates multi-cycle or variable IMEM latency with several requests in flight.
- Redirects (PCSrcE) flush the queue and discard stale in-flight responses.

---
 rtl/fetch_prefetch_stage.sv | 156 +++++++++++++++
 tb/tb_fetch_prefetch_stage.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_stage.sv
// Fetch stage: PC generation, pipelined IMEM requests, DEPTH-entry in-order prefetch queue, F/D register.
// An instruction reaches D two edges after its request handshake. Requests stop while the queue or in-flight budget is full.
module fetch_prefetch_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallF,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  localparam int unsigned    AW      = $clog2(DEPTH);
  localparam int unsigned    CW      = AW + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [AW-1:0]    alloc_ptr_q, alloc_ptr_d;
  logic [AW-1:0]    fill_ptr_q, fill_ptr_d;
  logic [AW-1:0]    head_ptr_q, head_ptr_d;
  logic [CW-1:0]    alloc_cnt_q, alloc_cnt_d;
  logic [CW-1:0]    inflight_q, inflight_d;
  logic [CW-1:0]    drop_q, drop_d;
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [XLEN-1:0]  pc_mem    [DEPTH];
  logic [XLEN-1:0]  instr_mem [DEPTH];

  logic [XLEN-1:0]  instr_fd_q, instr_fd_d;
  logic [XLEN-1:0]  pc_fd_q, pc_fd_d;
  logic [XLEN-1:0]  pc4_fd_q, pc4_fd_d;
  logic             valid_fd_q, valid_fd_d;

  logic push, pop, head_filled, rsp_fill, rsp_drop;

  assign imem_req_valid = rst && !PCSrcE && (alloc_cnt_q < DEPTH_C) && (inflight_q < DEPTH_C);
  assign imem_addr      = pc_q;
  assign push           = imem_req_valid && imem_req_ready;
  assign head_filled    = filled_q[head_ptr_q];
  assign pop            = head_filled && !StallF && !PCSrcE;
  assign rsp_drop       = imem_rsp_valid && (drop_q != '0);
  assign rsp_fill       = imem_rsp_valid && (drop_q == '0) && !PCSrcE;

  always_comb begin
    pc_d        = pc_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_ptr_d  = head_ptr_q;
    alloc_cnt_d = alloc_cnt_q;
    inflight_d  = inflight_q + CW'(push) - CW'(imem_rsp_valid);
    drop_d      = drop_q;
    filled_d    = filled_q;
    instr_fd_d  = instr_fd_q;
    pc_fd_d     = pc_fd_q;
    pc4_fd_d    = pc4_fd_q;
    valid_fd_d  = valid_fd_q;

    if (PCSrcE) begin
      // Every response still outstanding after this cycle belongs to the old path.
      pc_d        = {PCTargetE[XLEN-1:2], 2'b00};
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      head_ptr_d  = '0;
      alloc_cnt_d = '0;
      filled_d    = '0;
      drop_d      = inflight_q - CW'(imem_rsp_valid);
      instr_fd_d  = NOP_INSTR;
      pc_fd_d     = '0;
      pc4_fd_d    = '0;
      valid_fd_d  = 1'b0;
    end else begin
      if (push) begin
        pc_d        = pc_q + XLEN'(4);
        alloc_ptr_d = alloc_ptr_q + 1'b1;
      end
      alloc_cnt_d = alloc_cnt_q + CW'(push) - CW'(pop);
      if (rsp_drop) begin
        drop_d = drop_q - 1'b1;
      end
      if (rsp_fill) begin
        filled_d[fill_ptr_q] = 1'b1;
        fill_ptr_d           = fill_ptr_q + 1'b1;
      end
      if (pop) begin
        filled_d[head_ptr_q] = 1'b0;
        head_ptr_d           = head_ptr_q + 1'b1;
        instr_fd_d           = instr_mem[head_ptr_q];
        pc_fd_d              = pc_mem[head_ptr_q];
        pc4_fd_d             = pc_mem[head_ptr_q] + XLEN'(4);
        valid_fd_d           = 1'b1;
      end else if (!StallF) begin
        instr_fd_d = NOP_INSTR;
        pc_fd_d    = '0;
        pc4_fd_d   = '0;
        valid_fd_d = 1'b0;
      end
    end
  end

  // Entry payloads need no reset: the filled bits gate every read.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[alloc_ptr_q] <= pc_q;
    end
    if (rsp_fill) begin
      instr_mem[fill_ptr_q] <= imem_rsp_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= RESET_PC;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      alloc_cnt_q <= '0;
      inflight_q  <= '0;
      drop_q      <= '0;
      filled_q    <= '0;
      instr_fd_q  <= NOP_INSTR;
      pc_fd_q     <= '0;
      pc4_fd_q    <= '0;
      valid_fd_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      alloc_cnt_q <= alloc_cnt_d;
      inflight_q  <= inflight_d;
      drop_q      <= drop_d;
      filled_q    <= filled_d;
      instr_fd_q  <= instr_fd_d;
      pc_fd_q     <= pc_fd_d;
      pc4_fd_q    <= pc4_fd_d;
      valid_fd_q  <= valid_fd_d;
    end
  end

  assign InstrD   = instr_fd_q;
  assign PCD      = pc_fd_q;
  assign PCPlus4D = pc4_fd_q;
  assign ValidD   = valid_fd_q;

endmodule

// File: tb/tb_fetch_prefetch_stage.sv
// Bench for fetch_prefetch_stage: table-driven start-up sequence, hand-written corner cases, randomized run vs. an epoch-tagged model.
module tb_fetch_prefetch_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallF, PCSrcE, imem_req_ready, imem_rsp_valid;
  logic [31:0] PCTargetE, imem_rsp_data;
  logic        imem_req_valid, ValidD;
  logic [31:0] imem_addr, InstrD, PCD, PCPlus4D;

  fetch_prefetch_stage dut (
    .clk(clk), .rst(rst_n), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int ep; int due; } req_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; logic [31:0] pc4; logic vld; } dexp_t;
  typedef struct { logic stall; logic pcsrc; logic [31:0] target; logic exp_vld; logic [31:0] exp_pc; } vec_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int epoch = 0;
  int lat = 1;
  int delivered = 0;
  logic [31:0] next_pc;
  logic        last_req_vld;
  req_t        rq[$];
  logic [31:0] avail[$];
  dexp_t       exp_d;
  vec_t        tbl[13];

  function automatic logic [31:0] hashf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic vec_t mkv(input logic s, input logic p, input logic [31:0] t,
                               input logic v, input logic [31:0] pc);
    vec_t r;
    r.stall = s; r.pcsrc = p; r.target = t; r.exp_vld = v; r.exp_pc = pc;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic bubble_exp();
    exp_d.instr = NOP; exp_d.pc = 32'h0; exp_d.pc4 = 32'h0; exp_d.vld = 1'b0;
  endtask

  task automatic model_reset();
    rq.delete();
    avail.delete();
    epoch++;
    next_pc = 32'h0;
    bubble_exp();
  endtask

  // One clock: present the IMEM response, check the request side at negedge,
  // then check D and advance the model after the edge.
  task automatic tick();
    int   cur;
    logic hs;
    logic exp_req;
    req_t r;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = hashf(rq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    @(negedge clk);
    cur = 0;
    foreach (rq[i]) if (rq[i].ep == epoch) cur++;
    exp_req = !PCSrcE && ((cur + avail.size()) < DEPTH) && (rq.size() < DEPTH);
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
    if (imem_req_valid) chk("imem_addr", imem_addr, next_pc);
    last_req_vld = imem_req_valid;
    hs = imem_req_valid && imem_req_ready;
    @(posedge clk);
    cyc++;
    #1;
    if (PCSrcE) begin
      bubble_exp();
    end else if (!StallF) begin
      if (avail.size() > 0) begin
        exp_d.pc    = avail.pop_front();
        exp_d.instr = hashf(exp_d.pc);
        exp_d.pc4   = exp_d.pc + 32'd4;
        exp_d.vld   = 1'b1;
        delivered++;
      end else begin
        bubble_exp();
      end
    end
    chk("ValidD",   {31'b0, ValidD}, {31'b0, exp_d.vld});
    chk("InstrD",   InstrD,   exp_d.instr);
    chk("PCD",      PCD,      exp_d.pc);
    chk("PCPlus4D", PCPlus4D, exp_d.pc4);
    if (imem_rsp_valid) begin
      r = rq.pop_front();
      if (r.ep == epoch && !PCSrcE) avail.push_back(r.addr);
    end
    if (PCSrcE) begin
      epoch++;
      avail.delete();
      next_pc = {PCTargetE[31:2], 2'b00};
    end else if (hs) begin
      r.addr = next_pc;
      r.ep   = epoch;
      r.due  = cyc + lat - 1;
      if (rq.size() > 0 && rq[$].due + 1 > r.due) r.due = rq[$].due + 1;
      rq.push_back(r);
      next_pc = next_pc + 32'd4;
    end
  endtask

  task automatic wait_valid(input string nm, input logic [31:0] exp_pc);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (ValidD === 1'b1) break;
    end
    chk({nm, "_valid_seen"}, {31'b0, ValidD}, 32'd1);
    chk({nm, "_first_pc"}, PCD, exp_pc);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_ValidD"},   {31'b0, ValidD}, 32'd0);
    chk({nm, "_InstrD"},   InstrD,   NOP);
    chk({nm, "_PCD"},      PCD,      32'h0);
    chk({nm, "_PCPlus4D"}, PCPlus4D, 32'h0);
    chk({nm, "_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
  endtask

  initial begin
    tbl[0]  = mkv(0, 0, 0, 0, 32'h0);
    tbl[1]  = mkv(0, 0, 0, 0, 32'h0);
    tbl[2]  = mkv(0, 0, 0, 1, 32'h0);
    tbl[3]  = mkv(0, 0, 0, 1, 32'h4);
    tbl[4]  = mkv(0, 0, 0, 1, 32'h8);
    tbl[5]  = mkv(0, 0, 0, 1, 32'hC);
    tbl[6]  = mkv(1, 0, 0, 1, 32'hC);
    tbl[7]  = mkv(0, 0, 0, 1, 32'h10);
    tbl[8]  = mkv(0, 1, 32'h103, 0, 32'h0);
    tbl[9]  = mkv(0, 0, 0, 0, 32'h0);
    tbl[10] = mkv(0, 0, 0, 0, 32'h0);
    tbl[11] = mkv(0, 0, 0, 1, 32'h100);
    tbl[12] = mkv(0, 0, 0, 1, 32'h104);

    rst_n = 1'b0; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Start-up, stall, flush: cycle-exact with a 1-cycle IMEM.
    lat = 1;
    for (int i = 0; i < 13; i++) begin
      StallF = tbl[i].stall; PCSrcE = tbl[i].pcsrc; PCTargetE = tbl[i].target;
      tick();
      chk($sformatf("tbl%0d_ValidD", i), {31'b0, ValidD}, {31'b0, tbl[i].exp_vld});
      chk($sformatf("tbl%0d_PCD", i), PCD, tbl[i].exp_pc);
      chk($sformatf("tbl%0d_InstrD", i), InstrD, tbl[i].exp_vld ? hashf(tbl[i].exp_pc) : NOP);
      chk($sformatf("tbl%0d_PCPlus4D", i), PCPlus4D, tbl[i].exp_vld ? tbl[i].exp_pc + 32'd4 : 32'h0);
    end
    PCSrcE = 1'b0;

    // Long stall: queue fills, requests stop, then 4 back-to-back instructions.
    StallF = 1'b1;
    repeat (10) tick();
    chk("stall_full_req_valid", {31'b0, last_req_vld}, 32'd0);
    chk("stall_hold_PCD", PCD, 32'h104);
    StallF = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("release%0d_ValidD", i), {31'b0, ValidD}, 32'd1);
      chk($sformatf("release%0d_PCD", i), PCD, 32'h108 + 32'(4 * i));
    end

    // 3-cycle IMEM: redirect with responses in flight, then back-to-back redirects.
    lat = 3;
    repeat (8) tick();
    PCSrcE = 1'b1; PCTargetE = 32'h200;
    tick();
    chk("flush_ValidD", {31'b0, ValidD}, 32'd0);
    chk("flush_InstrD", InstrD, NOP);
    PCSrcE = 1'b0;
    wait_valid("redir200", 32'h200);
    repeat (4) tick();
    PCSrcE = 1'b1; PCTargetE = 32'h300;
    tick();
    PCTargetE = 32'h500;
    tick();
    PCSrcE = 1'b0;
    wait_valid("redir500", 32'h500);

    // Address wrap at the top of the space, target low bits masked.
    lat = 1;
    repeat (4) tick();
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFF9;
    tick();
    PCSrcE = 1'b0;
    wait_valid("wrap", 32'hFFFF_FFF8);
    tick();
    chk("wrap_PCD_FFC", PCD, 32'hFFFF_FFFC);
    chk("wrap_PCPlus4D_zero", PCPlus4D, 32'h0);
    tick();
    chk("wrap_PCD_zero", PCD, 32'h0);

    // Asynchronous reset with a full queue.
    StallF = 1'b1;
    repeat (8) tick();
    #3;
    rst_n = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    StallF = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_held");
    model_reset();
    rst_n = 1'b1;
    wait_valid("after_reset", 32'h0);

    // Randomized traffic against the model.
    delivered = 0;
    for (int i = 0; i < 3000; i++) begin
      StallF         = ($urandom_range(0, 4) == 0);
      imem_req_ready = ($urandom_range(0, 4) != 0);
      PCSrcE         = ($urandom_range(0, 39) == 0);
      PCTargetE      = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 + 32'($urandom_range(0, 31)))
                                                   : $urandom;
      lat            = $urandom_range(1, 4);
      tick();
    end
    chk("random_liveness", {31'b0, (delivered > 500)}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
